// File: rtl/trigger_cfg_sequencer.sv
// Converts SUMP trigger commands into one-cycle mask/value/config strobes and paces them around LUT downloads.
// Optional build macro TRIG_CFG_ORDER_CHECK_EN: drop value writes to stages with no prior mask write and flag err_order.
module trigger_cfg_sequencer #(
    parameter int LUT_CYCLES = 17
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [7:0]  i_cmd_opcode,
    input  logic [31:0] i_cmd_data,
    output logic [3:0]  o_wr_mask,
    output logic [3:0]  o_wr_value,
    output logic [3:0]  o_wr_config,
    output logic [31:0] o_config_data,
    output logic        o_arm,
    input  logic        i_run,
    output logic        o_busy,
    output logic        o_armed,
    output logic        o_triggered,
    output logic        o_err_order
);
    localparam int CW = (LUT_CYCLES < 1) ? 1 : $clog2(LUT_CYCLES + 1);
    localparam logic [CW-1:0] LUT_LOAD = CW'(LUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LUT_WAIT  = 2'd1,
        S_ARMED     = 2'd2,
        S_TRIGGERED = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_wr_mask;
    logic [3:0]    r_wr_value;
    logic [3:0]    r_wr_config;
    logic [31:0]   r_config_data;
    logic          r_arm;

    logic       w_accept;
    logic       w_is_cfg;
    logic       w_is_clear;
    logic       w_is_arm;
    logic       w_cfg_ok;
    logic       w_value_ok;
    logic       w_fwd_value;
    logic [1:0] w_stage;
    logic [1:0] w_kind;
    logic [3:0] w_stage_oh;

    assign w_accept    = i_cmd_valid & o_cmd_ready;
    assign w_is_cfg    = (i_cmd_opcode[7:4] == 4'hC);
    assign w_is_clear  = (i_cmd_opcode == 8'h00);
    assign w_is_arm    = (i_cmd_opcode == 8'h01);
    assign w_stage     = i_cmd_opcode[3:2];
    assign w_kind      = i_cmd_opcode[1:0];
    assign w_stage_oh  = 4'b0001 << w_stage;
    // Config writes only take effect from IDLE; while armed they are swallowed.
    assign w_cfg_ok    = w_accept & w_is_cfg & (r_state == S_IDLE);
    assign w_fwd_value = w_cfg_ok & (w_kind == 2'd1) & w_value_ok;

`ifdef TRIG_CFG_ORDER_CHECK_EN
    logic [3:0] r_mask_seen;
    logic       r_err_order;

    assign w_value_ok  = |(r_mask_seen & w_stage_oh);
    assign o_err_order = r_err_order;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mask_seen <= '0;
            r_err_order <= 1'b0;
        end else if (w_accept && w_is_clear) begin
            r_mask_seen <= '0;
            r_err_order <= 1'b0;
        end else begin
            if (w_cfg_ok && w_kind == 2'd0)
                r_mask_seen <= r_mask_seen | w_stage_oh;
            if (w_fwd_value)
                r_mask_seen <= r_mask_seen & ~w_stage_oh;
            if (w_cfg_ok && w_kind == 2'd1 && !w_value_ok)
                r_err_order <= 1'b1;
        end
    end
`else
    assign w_value_ok  = 1'b1;
    assign o_err_order = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_fwd_value)               w_state_nxt = S_LUT_WAIT;
                else if (w_accept && w_is_arm) w_state_nxt = S_ARMED;
            end
            S_LUT_WAIT: begin
                if (r_cnt <= CW'(1)) w_state_nxt = S_IDLE;
            end
            S_ARMED: begin
                if (w_accept && w_is_clear)    w_state_nxt = S_IDLE;
                else if (w_accept && w_is_arm) w_state_nxt = S_ARMED;
                else if (i_run)                w_state_nxt = S_TRIGGERED;
            end
            S_TRIGGERED: begin
                if (w_accept && w_is_clear)    w_state_nxt = S_IDLE;
                else if (w_accept && w_is_arm) w_state_nxt = S_ARMED;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_cmd_ready = (r_state != S_LUT_WAIT);
        o_busy      = (r_state == S_LUT_WAIT);
        o_armed     = (r_state == S_ARMED);
        o_triggered = (r_state == S_TRIGGERED);
    end

    // Saturating down-counter covering the capture cycle plus the serial LUT writes.
    always_ff @(posedge clock) begin
        if (reset)               r_cnt <= '0;
        else if (w_fwd_value)    r_cnt <= LUT_LOAD;
        else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_mask     <= '0;
            r_wr_value    <= '0;
            r_wr_config   <= '0;
            r_config_data <= '0;
            r_arm         <= 1'b0;
        end else begin
            r_wr_mask   <= '0;
            r_wr_value  <= '0;
            r_wr_config <= '0;
            r_arm       <= w_accept & w_is_arm;
            if (w_cfg_ok && w_kind == 2'd0) begin
                r_wr_mask     <= w_stage_oh;
                r_config_data <= i_cmd_data;
            end
            if (w_cfg_ok && w_kind == 2'd2) begin
                r_wr_config   <= w_stage_oh;
                r_config_data <= i_cmd_data;
            end
            if (w_fwd_value) begin
                r_wr_value    <= w_stage_oh;
                r_config_data <= i_cmd_data;
            end
        end
    end

    assign o_wr_mask     = r_wr_mask;
    assign o_wr_value    = r_wr_value;
    assign o_wr_config   = r_wr_config;
    assign o_config_data = r_config_data;
    assign o_arm         = r_arm;
endmodule

// File: doc/trigger_cfg_sequencer.md
# trigger_cfg_sequencer

- Sits between the SUMP command decoder and the 4-stage trigger.
- Accepts long commands over a valid/ready handshake and turns them into one-cycle mask, value and config write strobes for the trigger.
- Paces commands so that no new write lands while a trigger stage is serially downloading its 16-entry LUT.
- Sequences arming and latches the trigger's `run` output into a sticky triggered status.

## Interface

Parameters:
- `LUT_CYCLES`, default 17: cycles `cmd_ready` stays low after a value strobe (1 capture cycle + 16 LUT writes).

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command this cycle.
- `cmd_opcode`  in  8  SUMP opcode.
- `cmd_data`  in  32  command payload.
- `wr_mask`  out  4  one-hot mask write strobe, per stage.
- `wr_value`  out  4  one-hot value write strobe, per stage.
- `wr_config`  out  4  one-hot config write strobe, per stage.
- `config_data`  out  32  registered payload, valid with any strobe.
- `arm`  out  1  one-cycle arm pulse to the trigger.
- `run`  in  1  trigger run output.
- `busy`  out  1  LUT download in progress.
- `armed`  out  1  waiting for trigger.
- `triggered`  out  1  sticky; run was seen while armed.
- `err_order`  out  1  sticky ordering error (see Configuration).

## Operation

Handshake and opcode decode:
- A command is accepted on a clock edge where `cmd_valid & cmd_ready`.
- Config opcodes: `0xC0 + 4*s + k`, with s = stage 0..3 and k = 0 mask, 1 value, 2 config. k = 3 is consumed and ignored.
- `0x00` is a soft clear: go to IDLE and clear `armed`, `triggered` and `err_order`.
- `0x01` is arm.
- All other opcodes are consumed with no effect.

State machine (IDLE, LUT_WAIT, ARMED, TRIGGERED):
- IDLE, `cmd_ready`=1:
  - Mask or config command: issue the strobe and stay in IDLE.
  - Value command: issue the strobe and go to LUT_WAIT, loading the counter with `LUT_CYCLES`.
  - `0x01`: pulse `arm` and go to ARMED.
- LUT_WAIT, `cmd_ready`=0, `busy`=1:
  - Counter decrements each cycle.
  - Go to IDLE on the cycle the counter reaches 0.
- ARMED, `cmd_ready`=1:
  - Config opcodes are consumed and dropped, with no strobe.
  - `0x00`: go to IDLE.
  - `0x01`: re-pulse `arm` and stay in ARMED.
  - `run`=1 sampled at an edge: go to TRIGGERED.
- TRIGGERED, `cmd_ready`=1:
  - Same command handling as ARMED.
  - `run` is ignored.
  - `0x01` re-arms: pulse `arm` and go to ARMED.

Outputs per state:
- `armed`=1 only in ARMED.
- `triggered`=1 only in TRIGGERED.

Counter:
- Width is the minimum needed to hold `LUT_CYCLES`.
- It never wraps: it saturates at 0.

Simultaneous events:
- `run`=1 in the same cycle a `0x00` is accepted: `0x00` wins and the next state is IDLE.
- `run`=1 in the same cycle a `0x01` is accepted: the next state is ARMED and that `run` is ignored.

## Timing

- Strobe latency: any strobe (`wr_*`) or `arm` pulse is asserted exactly one cycle after the acceptance edge, for exactly one cycle.
- `config_data` is updated in the same cycle as the strobe and holds its value until the next strobe.
- After a value command is accepted, `cmd_ready` is low for exactly `LUT_CYCLES` cycles starting the cycle after acceptance.
  - `busy` is high in exactly the same cycles.
- `triggered` rises one cycle after the edge at which `run`=1 is sampled in ARMED.
- Reset values: IDLE, counter 0, `cmd_ready` 1, all strobes 0, `config_data` 0, `arm`, `busy`, `armed`, `triggered`, `err_order` 0.
  - Reset wins over any command accepted in the same cycle.
- Reset mid LUT_WAIT: go to IDLE on the next cycle.
  - The trigger clears its own LUT download on the same reset, so no extra wait is required.

## Configuration

`TRIG_CFG_ORDER_CHECK_EN`:
- Defined:
  - A per-stage `mask_seen` bit is set by a mask write and cleared by a value write to that stage.
  - A value command for a stage with `mask_seen`=0 is consumed and dropped: no strobe, no LUT_WAIT.
  - Such a dropped command sets `err_order` one cycle after acceptance.
  - `err_order` clears only on reset or `0x00`.
  - `mask_seen` bits clear on reset and `0x00`.
- Undefined:
  - Value writes are forwarded unconditionally.
  - `err_order` is tied to 0.

## Test plan

- Opcode `0xC0`, data 0x000000FF, then `0xC1`, data 0x00000055:
  - `wr_mask`=0001 one cycle after the first acceptance, `config_data`=0x000000FF.
  - `wr_value`=0001 one cycle after the second acceptance, `config_data`=0x00000055.
  - `cmd_ready`=0 and `busy`=1 for exactly 17 cycles after that.
- Opcode `0xCA` (stage 2 config), data 0x08000000:
  - `wr_config`=0100 for one cycle.
  - `cmd_ready` never drops.
- Opcode `0x01`:
  - `arm` is high for one cycle and `armed`=1.
  - Drive `run`=1 at cycle 5: `triggered`=1 at cycle 6 and stays 1 after `run` drops.
  - Then `0x00`: IDLE, `triggered`=0.
- Armed, then `0xC4` accepted: no strobe on `wr_mask`, state stays ARMED.
- Value command, then assert `reset` 5 cycles into LUT_WAIT: next cycle `cmd_ready`=1, `busy`=0, all outputs at reset values.
- With `TRIG_CFG_ORDER_CHECK_EN` defined, send `0xC5` with no prior `0xC4`:
  - No `wr_value` strobe, `busy` stays 0, `err_order`=1.
  - Without the macro: `wr_value`=0010 and `err_order`=0.
